// File: rtl/count_select_ctrl_pkg.sv
// Shared types and default constants for the item-count selection controller.
package count_select_ctrl_pkg;

    typedef enum logic [1:0] {
        StSelect,
        StIssue,
        StDone
    } state_e;

    localparam int unsigned MAX_COUNT_DEF = 5;
    localparam int unsigned CNT_W_DEF     = 3;
    // Short debounce window so simulations stay fast.
    localparam int unsigned DB_CYCLES_SIM = 4;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability-counter debounce and
// a registered one-cycle pulse on each debounced rising edge.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);

    logic          s1_q, s2_q;
    logic          db_q, db_d;
    logic          db_prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample equal to the current level restarts the stability count.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
            db_d  = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            press_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= btn;
            s2_q      <= s1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            press_q   <= db_q & ~db_prev_q;
            cnt_q     <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/count_select_ctrl.sv
// Item-count selection front end: debounced adjust/confirm buttons, wrapping
// count selection and a req/ack item issue sequencer.
module count_select_ctrl
    import count_select_ctrl_pkg::*;
#(
    parameter int unsigned MAX_COUNT = MAX_COUNT_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned DB_CYCLES = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw_dir,
    input  logic             btn_adj,
    input  logic             btn_ok,
    output logic [CNT_W-1:0] sel_count,
    output logic             busy,
    output logic             item_req,
    output logic [CNT_W-1:0] item_idx,
    input  logic             item_ack,
    output logic             done
);

    logic             adj_p, ok_p;
    logic             dir_s1_q, dir_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] idx_q, idx_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_adj (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_adj),
        .press (adj_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ok (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_ok),
        .press (ok_p)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        unique case (state_q)
            StSelect: begin
                // Confirm takes priority; a simultaneous adjust is dropped.
                if (ok_p) begin
                    if (sel_q != '0) begin
                        idx_d   = '0;
                        state_d = StIssue;
                    end
                end else if (adj_p) begin
                    if (dir_q) begin
                        sel_d = (sel_q == CNT_W'(MAX_COUNT)) ? '0 : sel_q + CNT_W'(1);
                    end else begin
                        sel_d = (sel_q == '0) ? CNT_W'(MAX_COUNT) : sel_q - CNT_W'(1);
                    end
                end
            end
            StIssue: begin
                if (item_ack) begin
                    if (idx_q == sel_q - CNT_W'(1)) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            StDone:  state_d = StSelect;
            default: state_d = StSelect;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_s1_q <= 1'b0;
            dir_q    <= 1'b0;
            state_q  <= StSelect;
            sel_q    <= '0;
            idx_q    <= '0;
        end else begin
            dir_s1_q <= sw_dir;
            dir_q    <= dir_s1_q;
            state_q  <= state_d;
            sel_q    <= sel_d;
            idx_q    <= idx_d;
        end
    end

    assign sel_count = sel_q;
    assign item_idx  = idx_q;
    assign item_req  = (state_q == StIssue);
    assign busy      = (state_q == StIssue);
    assign done      = (state_q == StDone);

endmodule
